// File: rtl/rr_arb_pkg.sv
// Shared types and index helpers for the round-robin hold arbiter.
// The state enum and pointer arithmetic live here so the top and the picker agree on them.
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_e;

    // Next-lower channel index, wrapping from 0 back to n-1.
    function automatic int rr_prev_idx(input int idx, input int n);
        return (idx == 0) ? (n - 1) : (idx - 1);
    endfunction

    // A valid one-hot vector has exactly one bit set, so OR-ing indices is enough.
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: search starts at the pointer channel and walks
// downward with wrap-around; the first requesting channel wins.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] ptr_i,
    output logic [NUM_REQ-1:0] winOh_o,
    output logic [IDX_W-1:0]   winIdx_o,
    output logic               anyReq_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   window;
    logic                 found;
    int                   ptrIdx;
    int                   pos;

    // After the shift, window[NUM_REQ-1-k] holds req[(ptr-k) mod NUM_REQ].
    always_comb begin
        ptrIdx   = onehot_to_idx(32'(ptr_i));
        dbl      = {req_i, req_i};
        window   = NUM_REQ'(dbl >> (ptrIdx + 1));
        found    = 1'b0;
        pos      = 0;
        winIdx_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && window[NUM_REQ-1-k]) begin
                found = 1'b1;
                pos   = ptrIdx + NUM_REQ - k;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                winIdx_o = IDX_W'(pos);
            end
        end
        winOh_o  = found ? (NUM_REQ'(1) << winIdx_o) : '0;
        anyReq_o = |req_i;
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold, done/release handshake and optional hold limit.
// The one-hot pointer only moves past the channel that was actually served.
module rr_hold_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int HOLD_MAX = 0,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] ptr
);

    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [NUM_REQ-1:0] PTR_RESET = {1'b1, {(NUM_REQ-1){1'b0}}};

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               grantValid_q;
    logic [IDX_W-1:0]   grantIdx_q;
    logic [NUM_REQ-1:0] ptr_q;
    logic [NUM_REQ-1:0] ptr_d;
    logic [CNT_W-1:0]   holdCnt_q;

    logic [NUM_REQ-1:0] winOh;
    logic [IDX_W-1:0]   winIdx;
    logic               anyReq;
    logic               releaseNow;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winOh_o  (winOh),
        .winIdx_o (winIdx),
        .anyReq_o (anyReq)
    );

    // The owner gives up the resource on done, on dropping its request, or at the hold limit.
    always_comb begin
        releaseNow = done || !req[grantIdx_q] ||
                     ((HOLD_MAX != 0) && (holdCnt_q == CNT_W'(HOLD_MAX)));
        ptr_d      = NUM_REQ'(1) << rr_prev_idx(int'(grantIdx_q), NUM_REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            grantValid_q <= 1'b0;
            grantIdx_q   <= '0;
            ptr_q        <= PTR_RESET;
            holdCnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && anyReq) begin
                        state_q      <= ST_GRANT;
                        grant_q      <= winOh;
                        grantValid_q <= 1'b1;
                        grantIdx_q   <= winIdx;
                        holdCnt_q    <= CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    // Release always passes through IDLE, so there is never a direct handoff.
                    if (releaseNow) begin
                        state_q      <= ST_IDLE;
                        grant_q      <= '0;
                        grantValid_q <= 1'b0;
                        grantIdx_q   <= '0;
                        ptr_q        <= ptr_d;
                        holdCnt_q    <= '0;
                    end else if ((HOLD_MAX != 0) && (holdCnt_q < CNT_W'(HOLD_MAX))) begin
                        holdCnt_q <= holdCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grantValid_q;
    assign grant_idx   = grantIdx_q;
    assign ptr         = ptr_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter (NUM_REQ=4, HOLD_MAX=3): directed scenarios followed by
// randomized traffic compared against a per-cycle behavioural model of the arbitration rules.
module tb_rr_hold_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int HOLD_MAX = 3;
    localparam logic [3:0] ROT_GRANT [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    localparam logic [3:0] ROT_PTR   [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       done;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] ptr;

    int total = 0;
    int bad   = 0;

    // Model state: owning channel (-1 when idle), cycles held, pointer channel index.
    int mOwner = -1;
    int mHold  = 0;
    int mPtr   = NUM_REQ - 1;

    rr_hold_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .ptr         (ptr)
    );

    always #5 clk = ~clk;

    task automatic modelStep();
        int idx;
        bit found;
        if (!rst_n) begin
            mOwner = -1;
            mHold  = 0;
            mPtr   = NUM_REQ - 1;
        end else if (mOwner < 0) begin
            found = 1'b0;
            if (en) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (mPtr - k + NUM_REQ) % NUM_REQ;
                    if (!found && req[idx]) begin
                        found  = 1'b1;
                        mOwner = idx;
                        mHold  = 1;
                    end
                end
            end
        end else if (done || !req[mOwner] || (HOLD_MAX != 0 && mHold == HOLD_MAX)) begin
            mPtr   = (mOwner + NUM_REQ - 1) % NUM_REQ;
            mOwner = -1;
            mHold  = 0;
        end else begin
            mHold = mHold + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;
        done  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (grant !== 4'b0000) begin
                $display("[TB] FAIL reset_grant: got %b want %b", grant, 4'b0000);
                bad++;
            end
            total++;
            if (ptr !== 4'b1000) begin
                $display("[TB] FAIL reset_ptr: got %b want %b", ptr, 4'b1000);
                bad++;
            end
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (grant !== 4'b1000) begin
            $display("[TB] FAIL first_grant: got %b want %b", grant, 4'b1000);
            bad++;
        end
        total++;
        if (grant_idx !== 2'd3) begin
            $display("[TB] FAIL first_idx: got %0d want %0d", grant_idx, 3);
            bad++;
        end
        total++;
        if (grant_valid !== 1'b1) begin
            $display("[TB] FAIL first_valid: got %b want %b", grant_valid, 1'b1);
            bad++;
        end
    endtask

    task automatic test_rotation();
        for (int i = 0; i < 4; i++) begin
            done = 1'b1;
            tick();
            total++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
                $display("[TB] FAIL rot_idle[%0d]: got %b/%b want 0000/0", i, grant, grant_valid);
                bad++;
            end
            total++;
            if (ptr !== ROT_PTR[i]) begin
                $display("[TB] FAIL rot_ptr[%0d]: got %b want %b", i, ptr, ROT_PTR[i]);
                bad++;
            end
            done = 1'b0;
            tick();
            total++;
            if (grant !== ROT_GRANT[i]) begin
                $display("[TB] FAIL rot_grant[%0d]: got %b want %b", i, grant, ROT_GRANT[i]);
                bad++;
            end
        end
    endtask

    task automatic test_sparse_wrap();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0100;
        tick();
        done = 1'b1;
        tick();
        total++;
        if (ptr !== 4'b0010) begin
            $display("[TB] FAIL wrap_setup_ptr: got %b want %b", ptr, 4'b0010);
            bad++;
        end
        done = 1'b0;
        req  = 4'b1000;
        tick();
        total++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            $display("[TB] FAIL wrap_grant: got %b idx %0d want 1000 idx 3", grant, grant_idx);
            bad++;
        end
        done = 1'b1;
        tick();
        total++;
        if (grant !== 4'b0000 || ptr !== 4'b0100) begin
            $display("[TB] FAIL wrap_release: got grant %b ptr %b want 0000 0100", grant, ptr);
            bad++;
        end
        done = 1'b0;
        req  = 4'b0000;
        tick();
    endtask

    task automatic test_hold_limit();
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (grant !== 4'b0001) begin
                $display("[TB] FAIL hold_on[%0d]: got %b want %b", c, grant, 4'b0001);
                bad++;
            end
        end
        tick();
        total++;
        if (grant !== 4'b0000 || ptr !== 4'b1000) begin
            $display("[TB] FAIL hold_expire: got grant %b ptr %b want 0000 1000", grant, ptr);
            bad++;
        end
        tick();
        total++;
        if (grant !== 4'b0001) begin
            $display("[TB] FAIL hold_regrant: got %b want %b", grant, 4'b0001);
            bad++;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_enable();
        en  = 1'b0;
        req = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (grant !== 4'b0000) begin
                $display("[TB] FAIL en_off[%0d]: got %b want %b", c, grant, 4'b0000);
                bad++;
            end
        end
        en = 1'b1;
        tick();
        total++;
        if (grant !== 4'b0100) begin
            $display("[TB] FAIL en_on: got %b want %b", grant, 4'b0100);
            bad++;
        end
        en = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0100) begin
            $display("[TB] FAIL en_drop_hold: got %b want %b", grant, 4'b0100);
            bad++;
        end
        req = 4'b0000;
        tick();
        total++;
        if (grant !== 4'b0000 || ptr !== 4'b0010) begin
            $display("[TB] FAIL req_drop: got grant %b ptr %b want 0000 0010", grant, ptr);
            bad++;
        end
        en = 1'b1;
    endtask

    task automatic test_reset_midgrant();
        req = 4'b0010;
        tick();
        total++;
        if (grant !== 4'b0010) begin
            $display("[TB] FAIL mid_setup: got %b want %b", grant, 4'b0010);
            bad++;
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            $display("[TB] FAIL mid_reset_grant: got %b/%b/%0d want 0000/0/0", grant, grant_valid, grant_idx);
            bad++;
        end
        total++;
        if (ptr !== 4'b1000) begin
            $display("[TB] FAIL mid_reset_ptr: got %b want %b", ptr, 4'b1000);
            bad++;
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] expGrant;
        logic       expValid;
        logic [1:0] expIdx;
        logic [3:0] expPtr;
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            en    = ($urandom_range(0, 7) != 0);
            done  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) begin
                req = 4'($urandom);
            end
            tick();
            expValid = (mOwner >= 0);
            expGrant = expValid ? 4'(1 << mOwner) : 4'b0000;
            expIdx   = expValid ? 2'(mOwner) : 2'd0;
            expPtr   = 4'(1 << mPtr);
            total++;
            if (grant !== expGrant) begin
                $display("[TB] FAIL rand_grant @%0d: got %b want %b", c, grant, expGrant);
                bad++;
            end
            total++;
            if (grant_valid !== expValid) begin
                $display("[TB] FAIL rand_valid @%0d: got %b want %b", c, grant_valid, expValid);
                bad++;
            end
            total++;
            if (grant_idx !== expIdx) begin
                $display("[TB] FAIL rand_idx @%0d: got %0d want %0d", c, grant_idx, expIdx);
                bad++;
            end
            total++;
            if (ptr !== expPtr) begin
                $display("[TB] FAIL rand_ptr @%0d: got %b want %b", c, ptr, expPtr);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_sparse_wrap();
        test_hold_limit();
        test_enable();
        test_reset_midgrant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
